// File: rtl/skip_sequencer_pkg.sv
// Shared skip-control definitions: opcode/funct encodings, condition codes, sequencer states.
// Also used by the hazard unit so both sides agree on what counts as a skip instruction.
package skip_sequencer_pkg;

  localparam int OP_RTYPE  = 0;
  localparam int OP_SKLT_I = 10;
  localparam int OP_SKEQ_I = 13;
  localparam int OP_SKNE_I = 14;

  localparam int F_SKNE = 3;
  localparam int F_SKEQ = 11;
  localparam int F_SKGT = 12;
  localparam int F_SKLT = 15;

  typedef enum logic [2:0] {C_NONE, C_EQ, C_NE, C_GT, C_LT} cond_t;

  typedef enum logic {IDLE, SKIP} state_t;

  // flags are packed {lessThan, greaterThan, isZero}
  function automatic logic cond_eval(input cond_t c, input logic [2:0] flags);
    logic r;
    r = 1'b0;
    case (c)
      C_EQ:    r = flags[0];
      C_NE:    r = ~flags[0];
      C_GT:    r = flags[1];
      C_LT:    r = flags[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/skip_cond_decode.sv
// Combinational skip decode: (opcode, funct) -> is-skip, condition code, immediate-length form.
// Zero latency; no flow control.
module skip_cond_decode
  import skip_sequencer_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 4
) (
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic               is_skip_instr,
  output cond_t              cond_code,
  output logic               is_imm
);

  always_comb begin
    cond_code = C_NONE;
    is_imm    = 1'b0;
    if (opcode == OP_W'(OP_RTYPE)) begin
      case (funct)
        FUNCT_W'(F_SKEQ): cond_code = C_EQ;
        FUNCT_W'(F_SKNE): cond_code = C_NE;
        FUNCT_W'(F_SKGT): cond_code = C_GT;
        FUNCT_W'(F_SKLT): cond_code = C_LT;
        default:          cond_code = C_NONE;
      endcase
    end else begin
      is_imm = 1'b1;
      case (opcode)
        OP_W'(OP_SKEQ_I): cond_code = C_EQ;
        OP_W'(OP_SKNE_I): cond_code = C_NE;
        OP_W'(OP_SKLT_I): cond_code = C_LT;
        default:          cond_code = C_NONE;
      endcase
    end
    is_skip_instr = (cond_code != C_NONE);
  end

endmodule

// File: rtl/skip_sequencer.sv
// Skip sequencer: registered ALU flags with same-cycle bypass, squashes the next N valid instructions.
// skip/squash are same-cycle combinational; skipping follows skip by one cycle; stalls hold the window.
module skip_sequencer
  import skip_sequencer_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 4,
  parameter int CNT_W   = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [CNT_W-1:0]   skipLen,
  input  logic               instrValid,
  input  logic               flagsValid,
  input  logic               isZero,
  input  logic               greaterThan,
  input  logic               lessThan,
  input  logic               flush,
  output logic               skip,
  output logic               squash,
  output logic               skipping,
  output logic [2:0]         flagsQ
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       flags_q, flags_d;

  logic             is_skip_instr;
  cond_t            cond_code;
  logic             is_imm;
  logic [2:0]       flags_in;
  logic [2:0]       flags_eff;
  logic [CNT_W-1:0] len;

  skip_cond_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .opcode        (Opcode),
    .funct         (funct),
    .is_skip_instr (is_skip_instr),
    .cond_code     (cond_code),
    .is_imm        (is_imm)
  );

  assign flags_in  = {lessThan, greaterThan, isZero};
  assign flags_eff = flagsValid ? flags_in : flags_q;
  assign len       = is_imm ? skipLen : CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flagsValid ? flags_in : flags_q;
    skip    = 1'b0;
    squash  = 1'b0;

    // Only IDLE decodes, so a skip instruction inside the window cannot nest.
    if (!Reset && !flush) begin
      case (state_q)
        IDLE: begin
          skip = instrValid & is_skip_instr & cond_eval(cond_code, flags_eff) & (len != '0);
          if (skip) begin
            state_d = SKIP;
            cnt_d   = len;
          end
        end
        SKIP: begin
          squash = instrValid;
          if (instrValid) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign skipping = (state_q == SKIP);
  assign flagsQ   = flags_q;

endmodule

// File: tb/tb_skip_sequencer.sv
// Directed-vector bench: each driven cycle queues its hand-computed outputs; a negedge monitor compares.
module tb_skip_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [3:0] fn;
  logic [2:0] sl;
  logic       iv, fv, z, gt, lt, fl;
  logic       skip_o, squash_o, skipping_o;
  logic [2:0] flags_o;

  int checks   = 0;
  int failures = 0;
  int cyc_idx  = 0;

  typedef struct {
    logic       s;
    logic       q;
    logic       k;
    logic [2:0] f;
    int         idx;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  skip_sequencer #(.OP_W(4), .FUNCT_W(4), .CNT_W(3)) dut (
    .CLK         (clk),
    .Reset       (rst),
    .Opcode      (opcode),
    .funct       (fn),
    .skipLen     (sl),
    .instrValid  (iv),
    .flagsValid  (fv),
    .isZero      (z),
    .greaterThan (gt),
    .lessThan    (lt),
    .flush       (fl),
    .skip        (skip_o),
    .squash      (squash_o),
    .skipping    (skipping_o),
    .flagsQ      (flags_o)
  );

  task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, idx, act, expv);
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic [3:0] f, input logic [2:0] len,
                     input logic i_v, input logic f_v, input logic i_z, input logic i_gt,
                     input logic i_lt, input logic i_fl, input logic i_rst,
                     input logic e_s, input logic e_q, input logic e_k, input logic [2:0] e_f);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; fn = f; sl = len; iv = i_v; fv = f_v;
    z = i_z; gt = i_gt; lt = i_lt; fl = i_fl; rst = i_rst;
    cyc_idx++;
    e.s = e_s; e.q = e_q; e.k = e_k; e.f = e_f; e.idx = cyc_idx;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("skip",     e.idx, {2'b00, skip_o},     {2'b00, e.s});
        chk("squash",   e.idx, {2'b00, squash_o},   {2'b00, e.q});
        chk("skipping", e.idx, {2'b00, skipping_o}, {2'b00, e.k});
        chk("flagsQ",   e.idx, flags_o,             e.f);
      end
    end
  end

  initial begin : stim
    rst = 1'b1; opcode = 4'd1; fn = 4'd0; sl = 3'd0;
    iv = 1'b0; fv = 1'b0; z = 1'b0; gt = 1'b0; lt = 1'b0; fl = 1'b0;
    @(posedge clk);
    #1;
    //   op     fn     sl    iv fv z  gt lt fl rst   skip sq  skpg flags
    // reset holds everything off even with a would-be skip presented
    cyc(4'd13, 4'd0,  3'd3, 1, 1, 1, 0, 0, 0, 1,   0, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    // R-type EQ with same-cycle flag bypass
    cyc(4'd0,  4'd11, 3'd0, 1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001);
    // bypass isZero=0 overrides stored isZero=1
    cyc(4'd0,  4'd11, 3'd0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    // I-type EQ len 3 from stored flags, stalls interleaved
    cyc(4'd1,  4'd0,  3'd0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    cyc(4'd13, 4'd0,  3'd3, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001);
    // NE with zero length never taken
    cyc(4'd14, 4'd0,  3'd0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    // LT len 7 (maximum); nested GT skip inside is squashed, its flags still land
    cyc(4'd10, 4'd0,  3'd7, 1, 1, 0, 0, 1, 0, 0,   1, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b100);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b100);
    cyc(4'd0,  4'd12, 3'd0, 1, 1, 0, 1, 0, 0, 0,   0, 1, 1, 3'b100);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b010);
    // flush after one squash of a len-4 window; flags written in flush cycle
    cyc(4'd13, 4'd0,  3'd4, 1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 1, 0, 0, 0, 1, 0,   0, 0, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    // flush in IDLE suppresses an otherwise taken skip
    cyc(4'd0,  4'd11, 3'd0, 1, 1, 1, 0, 0, 1, 0,   0, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001);
    // reset after two squashes of a len-5 window
    cyc(4'd13, 4'd0,  3'd5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 3'b001);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000);
    // remaining R-type conditions and non-skip encodings
    cyc(4'd0,  4'd12, 3'd0, 1, 1, 0, 1, 0, 0, 0,   1, 0, 0, 3'b000);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd0,  4'd3,  3'd0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 3'b010);
    cyc(4'd0,  4'd15, 3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b010);
    cyc(4'd0,  4'd15, 3'd0, 1, 1, 0, 0, 1, 0, 0,   1, 0, 0, 3'b010);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 3'b100);
    cyc(4'd0,  4'd5,  3'd0, 1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 3'b100);
    cyc(4'd13, 4'd0,  3'd2, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b111);
    cyc(4'd1,  4'd0,  3'd0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b111);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
